mult_sequencer: RTL and testbench

Control FSM for the 8-bit signed shift-add multiplier datapath (X/A/B registers, 9-bit adder, S operand switches). It converts the Run and ClearA_LoadB button levels into per-cycle register and adder controls. It executes eight add/subtract-then-shift iterations, producing the 16-bit two's-complement product in A:B. It sits between the button inputs and the datapath registers, in place of any ad-hoc control glue.

---
 rtl/mult_sequencer.sv | 113 +++++++++++
 tb/tb_mult_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_sequencer.sv
// mult_sequencer: control FSM for the 8-bit signed shift-add multiplier.
// Turns the Run / ClearA_LoadB button levels into per-cycle datapath
// controls. A run is CLEAR, then eight ADD/SHIFT pairs, then DONE.
// The last ADD subtracts, because the MSB of a two's-complement
// multiplier carries negative weight.
// Inputs are plain levels. There is no valid/ready handshake. Run is
// acted on only in IDLE, and a held Run parks the FSM in DONE until Run
// goes low.
module mult_sequencer (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       ClearA_LoadB,
  input  logic       M,
  output logic       Clr_XA,
  output logic       Ld_B,
  output logic       Ld_XA,
  output logic       Add,
  output logic       Sub,
  output logic       Shift_En,
  output logic       Busy,
  output logic       Done,
  output logic [2:0] Iter,
  output logic [2:0] Dbg_State
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic [2:0] r_cnt;
  logic       w_last;

  assign w_last    = (r_cnt == 3'd7);
  assign Iter      = r_cnt;
  assign Dbg_State = r_state;

  // State register; reset returns to IDLE from anywhere, abandoning a run.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Iteration counter: zeroed on entry to a run and after the last shift.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cnt <= 3'd0;
    end else begin
      case (r_state)
        S_CLEAR: r_cnt <= 3'd0;
        S_SHIFT: r_cnt <= w_last ? 3'd0 : r_cnt + 3'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Next-state logic; button changes mid-run are ignored.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (Run) w_next = S_CLEAR;
      S_CLEAR: w_next = S_ADD;
      S_ADD:   w_next = S_SHIFT;
      S_SHIFT: w_next = w_last ? S_DONE : S_ADD;
      S_DONE:  if (!Run) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode. Everything is forced low while Reset is high, so the
  // IDLE clear/load path cannot fire during reset.
  always_comb begin
    Clr_XA   = 1'b0;
    Ld_B     = 1'b0;
    Ld_XA    = 1'b0;
    Add      = 1'b0;
    Sub      = 1'b0;
    Shift_En = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    if (!Reset) begin
      case (r_state)
        S_IDLE: begin
          if (!Run && ClearA_LoadB) begin
            Clr_XA = 1'b1;
            Ld_B   = 1'b1;
          end
        end
        S_CLEAR: begin
          Clr_XA = 1'b1;
          Busy   = 1'b1;
        end
        S_ADD: begin
          Ld_XA = M;
          Add   = M & ~w_last;
          Sub   = M & w_last;
          Busy  = 1'b1;
        end
        S_SHIFT: begin
          Shift_En = 1'b1;
          Busy     = 1'b1;
        end
        S_DONE:  Done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer: drives mult_sequencer together with a small datapath
// model (X/A/B registers and a 9-bit adder). Expected products come from
// signed multiplication in the bench. Expected control timelines come
// from the multiplier bits.
module tb_mult_sequencer;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Run = 1'b0;
  logic       ClearA_LoadB = 1'b0;
  logic       M;
  logic       Clr_XA, Ld_B, Ld_XA, Add, Sub, Shift_En, Busy, Done;
  logic [2:0] Iter;
  logic [2:0] Dbg_State;

  logic [7:0] s_in = 8'h00;
  logic       x_reg = 1'b0;
  logic [7:0] a_reg = 8'h00;
  logic [7:0] b_reg = 8'h00;
  logic [8:0] w_op;
  logic [8:0] w_sum;

  int chk_cnt  = 0;
  int fail_cnt = 0;
  int excl_err = 0;
  logic [15:0] exp_q[$];

  mult_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
    .Clr_XA(Clr_XA), .Ld_B(Ld_B), .Ld_XA(Ld_XA), .Add(Add), .Sub(Sub),
    .Shift_En(Shift_En), .Busy(Busy), .Done(Done), .Iter(Iter),
    .Dbg_State(Dbg_State)
  );

  // Clock
  always #5 Clk = ~Clk;

  // Datapath model controlled by the DUT outputs
  assign M     = b_reg[0];
  assign w_op  = Sub ? (9'd0 - {s_in[7], s_in}) : {s_in[7], s_in};
  assign w_sum = {a_reg[7], a_reg} + w_op;

  always @(posedge Clk) begin
    if (Clr_XA) begin
      x_reg <= 1'b0;
      a_reg <= 8'h00;
    end else if (Ld_XA) begin
      {x_reg, a_reg} <= w_sum;
    end else if (Shift_En) begin
      a_reg <= {x_reg, a_reg[7:1]};
      b_reg <= {a_reg[0], b_reg[7:1]};
    end
    if (Ld_B) b_reg <= s_in;
  end

  // Mutual-exclusion monitor, sampled just before every edge
  always @(negedge Clk) begin
    if (Add && Sub) excl_err++;
    if ((32'(Ld_XA) + 32'(Shift_En) + 32'(Clr_XA)) > 1) excl_err++;
  end

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [10:0] outs();
    return {Clr_XA, Ld_B, Ld_XA, Add, Sub, Shift_En, Busy, Done, Iter};
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Load B with b, run one multiply by s, hold Run for 'hold' extra DONE
  // cycles, then release and check the return to IDLE.
  task automatic run_mult(input logic [7:0] b, input logic [7:0] s, input int hold);
    logic [63:0] add_m, sub_m, ldxa_m, sh_m, clr_m, ldb_m, busy_m, done_m;
    logic [63:0] e_add, e_sub, e_ldxa, e_sh, e_done;
    logic signed [15:0] prod;
    int iter_err;
    int last;
    bit got;
    s_in = b;
    ClearA_LoadB = 1'b1;
    step();
    ClearA_LoadB = 1'b0;
    s_in = s;
    prod = $signed({{8{b[7]}}, b}) * $signed({{8{s[7]}}, s});
    exp_q.push_back(prod);
    e_add = '0; e_sub = '0; e_ldxa = '0; e_sh = '0; e_done = '0;
    for (int i = 0; i < 8; i++) begin
      e_sh[3 + 2 * i] = 1'b1;
      if (b[i]) begin
        e_ldxa[2 + 2 * i] = 1'b1;
        if (i < 7) e_add[2 + 2 * i] = 1'b1;
        else       e_sub[16] = 1'b1;
      end
    end
    last = 18 + hold;
    for (int c = 18; c <= last; c++) e_done[c] = 1'b1;
    add_m = '0; sub_m = '0; ldxa_m = '0; sh_m = '0; clr_m = '0;
    ldb_m = '0; busy_m = '0; done_m = '0;
    iter_err = 0;
    got = 1'b0;
    Run = 1'b1;
    @(posedge Clk);  // edge 0
    for (int c = 1; c <= last; c++) begin
      #1;
      add_m[c] = Add;  sub_m[c] = Sub;  ldxa_m[c] = Ld_XA;
      sh_m[c] = Shift_En;  clr_m[c] = Clr_XA;  ldb_m[c] = Ld_B;
      busy_m[c] = Busy;  done_m[c] = Done;
      if (Iter !== ((c >= 2 && c <= 17) ? 3'((c - 2) / 2) : 3'd0)) iter_err++;
      if (Done && !got) begin
        got = 1'b1;
        if (exp_q.size() > 0) check_val("product", {a_reg, b_reg}, exp_q.pop_front());
      end
      if (c < last) @(posedge Clk);
    end
    check_val("add_cycles", add_m, e_add);
    check_val("sub_cycles", sub_m, e_sub);
    check_val("ldxa_cycles", ldxa_m, e_ldxa);
    check_val("shift_cycles", sh_m, e_sh);
    check_val("clr_cycles", clr_m, 64'h2);
    check_val("ldb_cycles", ldb_m, 64'h0);
    check_val("busy_cycles", busy_m, 64'h3_FFFE);
    check_val("done_cycles", done_m, e_done);
    check_val("iter_err", iter_err, 0);
    check_val("done_seen", got, 1);
    Run = 1'b0;
    step();
    check_val("idle_after_done", {Dbg_State, outs()}, {3'd0, 11'd0});
  endtask

  initial begin
    int n_clr, n_ldb;
    // Reset held 3 cycles with both buttons high
    Run = 1'b1;
    ClearA_LoadB = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_val("reset_outs", outs(), 11'd0);
      step();
    end
    check_val("reset_state", Dbg_State, 3'd0);
    Run = 1'b0;
    ClearA_LoadB = 1'b0;
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("post_reset", {Dbg_State, outs()}, {3'd0, 11'd0});
    end

    // ClearA_LoadB alone for 3 cycles within a 5-cycle window
    n_clr = 0;
    n_ldb = 0;
    for (int i = 0; i < 5; i++) begin
      ClearA_LoadB = (i < 3);
      #1;
      n_clr += int'(Clr_XA);
      n_ldb += int'(Ld_B);
      step();
    end
    check_val("clr_hold_cnt", n_clr, 3);
    check_val("ldb_hold_cnt", n_ldb, 3);
    check_val("clr_hold_state", Dbg_State, 3'd0);

    // Run and ClearA_LoadB together: Run wins
    Run = 1'b1;
    ClearA_LoadB = 1'b1;
    #1;
    check_val("run_prio_ldb", {Clr_XA, Ld_B}, 2'b00);
    step();
    check_val("run_prio_state", Dbg_State, 3'd1);
    check_val("run_prio_clr", Clr_XA, 1'b1);
    for (int i = 0; i < 40 && !Done; i++) step();
    check_val("run_prio_done", Done, 1'b1);
    Run = 1'b0;
    ClearA_LoadB = 1'b0;
    step();
    check_val("run_prio_idle", Dbg_State, 3'd0);

    // Directed multiplies
    run_mult(8'h03, 8'h07, 0);
    run_mult(8'h80, 8'h05, 0);
    run_mult(8'hFF, 8'hFF, 10);
    run_mult(8'hFF, 8'hFF, 0);

    // Reset asserted in the middle of cycle 9
    s_in = 8'h55;
    ClearA_LoadB = 1'b1;
    step();
    ClearA_LoadB = 1'b0;
    s_in = 8'h33;
    Run = 1'b1;
    @(posedge Clk);  // edge 0
    for (int c = 1; c < 9; c++) @(posedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    check_val("midreset_outs", outs(), 11'd0);
    check_val("midreset_state", Dbg_State, 3'd0);
    Run = 1'b0;
    step();
    Reset = 1'b0;
    step();
    check_val("midreset_idle", {Dbg_State, outs()}, {3'd0, 11'd0});
    run_mult(8'h03, 8'h07, 0);

    // Random multiplies
    for (int k = 0; k < 6; k++)
      run_mult(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));

    check_val("exclusive_ctrl", excl_err, 0);
    check_val("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: sim time limit reached, expected finish");
    $fatal(1);
  end

endmodule
